// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
//   CNT_W_DEF   : default divisor/counter width
//   DEF_DIV_DEF : default divisor loaded into every channel at reset
//   ch_w()      : width of the channel-index field (at least 1 bit)
package clk_div_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int DEF_DIV_DEF = 5;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor configuration handshake.
//   cfg_valid/cfg_ready : write request / accept (accepted when both high)
//   cfg_ch              : target channel index
//   cfg_div             : requested divisor (0 disables the channel)
//   cfg_err             : one-cycle pulse after an accepted illegal write
interface clk_div_multi_if import clk_div_pkg::*; #(
    parameter int NCH   = 4,
    parameter int CNT_W = CNT_W_DEF
) ();
    localparam int CHW = ch_w(NCH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_ch, cfg_div, input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: active divisor, counter, pending divisor and the
// registered dclk/tick outputs.
//   clk, rst_n  : clock, async active-low reset
//   i_restart   : restart edge (one cycle) from the top
//   i_wr        : accepted legal write addressed to this channel
//   i_wr_div    : divisor carried by that write
//   o_pend_vld  : a divisor is waiting for the next wrap
//   o_dclk      : divided clock (flop output)
//   o_tick      : one-cycle pulse in the cycle o_dclk rises
module clk_div_ch import clk_div_pkg::*; #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_restart,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_pend_vld,
    output logic             o_dclk,
    output logic             o_tick
);
    logic [CNT_W-1:0] r_p, r_cnt, r_pend;
    logic             r_pend_vld, r_dclk, r_tick;
    logic [CNT_W-1:0] w_p_nxt, w_cnt_nxt, w_pend_nxt;
    logic             w_pend_vld_nxt, w_dclk_nxt, w_wrap;

    assign w_wrap = (r_cnt == r_p - CNT_W'(1));

    always_comb begin
        w_p_nxt        = r_p;
        w_cnt_nxt      = r_cnt;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        if (i_restart) begin
            // A write landing with the restart is taken at once, otherwise
            // any pending divisor is committed.
            w_cnt_nxt      = '0;
            w_pend_vld_nxt = 1'b0;
            if (i_wr)            w_p_nxt = i_wr_div;
            else if (r_pend_vld) w_p_nxt = r_pend;
        end else if (r_p == '0) begin
            // Idle channel: no period to protect, apply directly.
            w_cnt_nxt = '0;
            if (i_wr) w_p_nxt = i_wr_div;
        end else begin
            if (w_wrap) begin
                w_cnt_nxt = '0;
                if (r_pend_vld) begin
                    w_p_nxt        = r_pend;
                    w_pend_vld_nxt = 1'b0;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            // cfg_ready gating guarantees i_wr never meets r_pend_vld.
            if (i_wr) begin
                w_pend_nxt     = i_wr_div;
                w_pend_vld_nxt = 1'b1;
            end
        end
        // dclk is computed from next-state so the flop output matches
        // (cnt >= P>>1) in the same cycle as the counter.
        w_dclk_nxt = (w_p_nxt != '0) && (w_cnt_nxt >= (w_p_nxt >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p        <= CNT_W'(DEF_DIV);
            r_cnt      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_dclk     <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_p        <= w_p_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_dclk     <= w_dclk_nxt;
            r_tick     <= w_dclk_nxt & ~r_dclk;
        end
    end

    assign o_pend_vld = r_pend_vld;
    assign o_dclk     = r_dclk;
    assign o_tick     = r_tick;
endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
//   clk, rst_n : clock, async active-low reset
//   restart    : level; each edge restarts every channel
//   cfg        : divisor write handshake (slave side)
//   dclk       : divided clocks, one per channel
//   tick       : rising-edge pulse per channel
module clk_div_multi import clk_div_pkg::*; #(
    parameter int NCH     = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           restart,
    clk_div_multi_if.slave cfg,
    output logic [NCH-1:0] dclk,
    output logic [NCH-1:0] tick
);
    localparam int CHW = ch_w(NCH);

    logic           r_rst_d, r_err;
    logic           w_edge, w_ch_ok, w_ready, w_acc, w_bad;
    logic [NCH-1:0] w_pend_vld, w_wr;

    // Reset value 0 means restart held high at release counts as one edge.
    assign w_edge  = restart ^ r_rst_d;
    assign w_ch_ok = int'(cfg.cfg_ch) < NCH;

    // Out-of-range channels are always accepted so the error can be flagged.
    always_comb begin
        w_ready = 1'b1;
        if (w_ch_ok) w_ready = ~w_pend_vld[cfg.cfg_ch];
    end

    assign w_acc = cfg.cfg_valid & w_ready;
    assign w_bad = (cfg.cfg_div == CNT_W'(1)) | ~w_ch_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_d <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rst_d <= restart;
            r_err   <= w_acc & w_bad;
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign cfg.cfg_err   = r_err;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_wr[i] = w_acc & ~w_bad & (cfg.cfg_ch == CHW'(i));

        clk_div_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_restart  (w_edge),
            .i_wr       (w_wr[i]),
            .i_wr_div   (cfg.cfg_div),
            .o_pend_vld (w_pend_vld[i]),
            .o_dclk     (dclk[i]),
            .o_tick     (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
    localparam int NCH = 3, CNT_W = 8, DEF_DIV = 5, CHW = 2;

    logic           clk = 1'b0, rst_n = 1'b1, restart = 1'b0;
    logic [NCH-1:0] dclk, tick;

    clk_div_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) cfg_if ();

    clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .cfg(cfg_if), .dclk(dclk), .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: integer divisor / phase per channel.
    int             m_p[NCH], m_cnt[NCH], m_pend[NCH];
    bit             m_pvld[NCH];
    bit             m_rst_d, m_err;
    bit [NCH-1:0]   m_dclk, m_tick;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int ch);
        return (ch >= NCH) || !m_pvld[ch];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_p[i] = DEF_DIV; m_cnt[i] = 0; m_pend[i] = 0; m_pvld[i] = 0;
        end
        m_rst_d = 0; m_err = 0; m_dclk = '0; m_tick = '0;
    endtask

    task automatic m_clock(input bit rs, input bit v, input int ch, input int div);
        bit acc, bad, edg, wr;
        bit [NCH-1:0] prev;
        acc = v && m_ready(ch);
        bad = (div == 1) || (ch >= NCH);
        edg = (rs != m_rst_d);
        m_rst_d = rs;
        m_err = acc && bad;
        prev = m_dclk;
        for (int i = 0; i < NCH; i++) begin
            wr = acc && !bad && (ch == i);
            if (edg) begin
                if (wr) m_p[i] = div; else if (m_pvld[i]) m_p[i] = m_pend[i];
                m_cnt[i] = 0; m_pvld[i] = 0;
            end else if (m_p[i] == 0) begin
                if (wr) m_p[i] = div;
            end else begin
                m_cnt[i] = (m_cnt[i] + 1) % m_p[i];
                if (m_cnt[i] == 0 && m_pvld[i]) begin m_p[i] = m_pend[i]; m_pvld[i] = 0; end
                if (wr) begin m_pend[i] = div; m_pvld[i] = 1; end
            end
            m_dclk[i] = (m_p[i] != 0) && (m_cnt[i] >= m_p[i] / 2);
        end
        m_tick = m_dclk & ~prev;
    endtask

    // One clock: drive, check ready before the edge, check outputs after.
    task automatic step(input bit rs, input bit v, input int ch, input int div);
        restart = rs;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = CHW'(ch);
        cfg_if.cfg_div   = CNT_W'(div);
        @(negedge clk);
        chk("cfg_ready", int'(cfg_if.cfg_ready), int'(m_ready(ch)));
        @(posedge clk);
        m_clock(rs, v, ch, div);
        #1;
        chk("dclk", int'(dclk), int'(m_dclk));
        chk("tick", int'(tick), int'(m_tick));
        chk("cfg_err", int'(cfg_if.cfg_err), int'(m_err));
    endtask

    task automatic idle(); step(restart, 1'b0, 0, 0); endtask

    task automatic do_reset(input bit rs);
        rst_n = 1'b0; restart = rs; cfg_if.cfg_valid = 1'b0;
        #1;
        chk("rst_dclk", int'(dclk), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_err", int'(cfg_if.cfg_err), 0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input int ch, input int val, input string nm);
        int n = 0;
        while (m_cnt[ch] != val && n < 40) begin idle(); n++; end
        checks++;
        if (m_cnt[ch] != val) begin failures++; $display("FAIL %s: timeout after %0d cycles", nm, n); end
    endtask

    typedef struct {
        bit v; int ch; int div;
        bit rdy; bit d0; bit t0; bit err;
    } vec_t;

    initial begin
        vec_t     tbl[10];
        bit [5:0] pat;
        int       n;

        // Post-reset ch0 with DEF_DIV=5 (0,0,1,1,1), plus two illegal writes.
        tbl[0] = '{0, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 2, 1, 1, 1, 1, 1};   // divisor 1 rejected
        tbl[2] = '{1, 3, 7, 1, 1, 0, 1};   // channel out of range
        tbl[3] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 1, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 1, 1, 1, 0};
        tbl[7] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[8] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[9] = '{0, 0, 0, 1, 0, 0, 0};

        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
        #2;
        do_reset(1'b0);

        for (int k = 0; k < 10; k++) begin
            step(1'b0, tbl[k].v, tbl[k].ch, tbl[k].div);
            chk($sformatf("tbl%0d_dclk0", k), int'(dclk[0]), int'(tbl[k].d0));
            chk($sformatf("tbl%0d_tick0", k), int'(tick[0]), int'(tbl[k].t0));
            chk($sformatf("tbl%0d_err", k), int'(cfg_if.cfg_err), int'(tbl[k].err));
            chk($sformatf("tbl%0d_rdy", k), int'(cfg_if.cfg_ready), int'(tbl[k].rdy));
        end

        // Ch1 retarget to 4 mid-period; a second write waits for the wrap.
        wait_cnt(1, 1, "wait_ch1_cnt1");
        step(1'b0, 1'b1, 1, 4);
        n = 0;
        while (!m_ready(1) && n < 20) begin step(1'b0, 1'b1, 1, 6); n++; end
        chk("ch1_blocked_cycles", n, 3);
        pat[0] = dclk[1];
        step(1'b0, 1'b1, 1, 6);               // accepted right after the wrap
        pat[1] = dclk[1];
        chk("ch1_second_wr_pending", int'(cfg_if.cfg_ready), 0);
        idle(); pat[2] = dclk[1];
        idle(); pat[3] = dclk[1];
        chk("ch1_new_period_pat", int'(pat[3:0]), 4'b1100);

        // Ch2: divisor 1 errors, divisor 0 stops it at the next wrap.
        step(1'b0, 1'b1, 2, 1);
        chk("ch2_err_pulse", int'(cfg_if.cfg_err), 1);
        idle();
        chk("ch2_err_one_cycle", int'(cfg_if.cfg_err), 0);
        step(1'b0, 1'b1, 2, 0);
        n = 0;
        while (m_p[2] != 0 && n < 20) begin idle(); n++; end
        for (int k = 0; k < 6; k++) begin idle(); chk("ch2_disabled", int'(dclk[2]), 0); end

        // Restart on both edges with a pending divisor 6 on ch0.
        wait_cnt(0, 2, "wait_ch0_cnt2");
        step(1'b0, 1'b1, 0, 6);
        idle();
        step(1'b1, 1'b0, 0, 0);
        chk("restart_rise_dclk", int'(dclk), 0);
        pat[0] = dclk[0];
        for (int k = 1; k < 6; k++) begin idle(); pat[k] = dclk[0]; end
        chk("ch0_after_restart_pat", int'(pat), 6'b111000);
        idle();
        step(1'b0, 1'b0, 0, 0);
        chk("restart_fall_dclk", int'(dclk), 0);
        idle(); idle();
        step(1'b1, 1'b1, 1, 3);               // write coinciding with restart
        chk("restart_wr_ready", int'(cfg_if.cfg_ready), 1);
        idle(); idle(); idle(); idle();

        // Async reset mid-period with a pending write on ch0.
        step(1'b1, 1'b1, 0, 7);
        chk("pend_set_before_rst", int'(cfg_if.cfg_ready), 0);
        do_reset(1'b0);
        for (int k = 0; k < 11; k++) idle();
        step(1'b0, 1'b0, 0, 0);
        chk("rst_pend_cleared", int'(cfg_if.cfg_ready), 1);

        // Restart held high across reset release: one restart, then run.
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0, 0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bit rs, v;
            int ch, div, r;
            rs = restart;
            if ($urandom_range(15) == 0) rs = ~rs;
            v  = ($urandom_range(2) == 0);
            ch = $urandom_range(3);
            r  = $urandom_range(7);
            div = (r == 0) ? 0 : (r == 1) ? 1 : (r == 7) ? $urandom_range(20, 2) : $urandom_range(9, 2);
            step(rs, v, ch, div);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
